// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: credit-based issue of 8-bit ALU ops with an in-order show-ahead response FIFO.
// Optional self-check (shadow expected results driving chk_err) enabled by ALU_ISSUE_CHECK_EN.
module alu_issue_ctrl #(
  parameter int ALU_LAT    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [3:0] req_ctr,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_ctr,
  input  logic [7:0] alu_o,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_ctr,
  output logic       rsp_ill,
  output logic       busy
`ifdef ALU_ISSUE_CHECK_EN
  ,
  output logic       chk_err
`endif
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  function automatic logic is_legal(input logic [3:0] c);
    case (c)
      4'b0000, 4'b0001, 4'b1001, 4'b1010, 4'b1011,
      4'b1100, 4'b1101, 4'b1110, 4'b1111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  logic               accept, push, pop, req_legal;
  logic               req_ready_reg;
  logic [7:0]         alu_a_reg, alu_b_reg;
  logic [3:0]         alu_ctr_reg;
  logic [ALU_LAT-1:0] dl_valid_reg, dl_ill_reg;
  logic [3:0]         dl_ctr_reg [ALU_LAT];
  logic [15:0]        pc [ALU_LAT+1];
  logic [15:0]        inflight, total_next;
  logic [7:0]         mem_data [FIFO_DEPTH];
  logic [3:0]         mem_ctr [FIFO_DEPTH];
  logic               mem_ill [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]      count_reg;

  assign req_legal = is_legal(req_ctr);
  assign accept    = req_valid & req_ready_reg;
  assign push      = dl_valid_reg[ALU_LAT-1];
  assign pop       = rsp_valid & rsp_ready;

  // inflight = popcount of the delay-line valid bits
  assign pc[0] = '0;
  generate
    for (genvar gi = 0; gi < ALU_LAT; gi++) begin : g_pc
      assign pc[gi+1] = pc[gi] + {15'd0, dl_valid_reg[gi]};
    end
  endgenerate
  assign inflight = pc[ALU_LAT];

  // A push moves an op from inflight to the FIFO, so only accept and pop change the total
  assign total_next = inflight + 16'(count_reg) + {15'd0, accept} - {15'd0, pop};

  always_ff @(posedge ck) begin
    if (rst) begin
      req_ready_reg <= 1'b0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_ctr_reg   <= '0;
      dl_valid_reg  <= '0;
      dl_ill_reg    <= '0;
      for (int i = 0; i < ALU_LAT; i++) dl_ctr_reg[i] <= '0;
    end else begin
      req_ready_reg <= total_next < 16'(FIFO_DEPTH);
      if (accept && req_legal) begin
        alu_a_reg   <= req_a;
        alu_b_reg   <= req_b;
        alu_ctr_reg <= req_ctr;
      end
      dl_valid_reg[0] <= accept;
      dl_ill_reg[0]   <= ~req_legal;
      dl_ctr_reg[0]   <= req_ctr;
      for (int i = 1; i < ALU_LAT; i++) begin
        dl_valid_reg[i] <= dl_valid_reg[i-1];
        dl_ill_reg[i]   <= dl_ill_reg[i-1];
        dl_ctr_reg[i]   <= dl_ctr_reg[i-1];
      end
    end
  end

  always_ff @(posedge ck) begin
    if (push && !rst) begin
      mem_data[wr_ptr_reg] <= dl_ill_reg[ALU_LAT-1] ? 8'h00 : alu_o;
      mem_ctr[wr_ptr_reg]  <= dl_ctr_reg[ALU_LAT-1];
      mem_ill[wr_ptr_reg]  <= dl_ill_reg[ALU_LAT-1];
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push) count_reg <= count_reg - CW'(1);
    end
  end

  assign req_ready = req_ready_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_ctr   = alu_ctr_reg;
  assign rsp_valid = (count_reg != '0);
  assign rsp_data  = rsp_valid ? mem_data[rd_ptr_reg] : 8'h00;
  assign rsp_ctr   = rsp_valid ? mem_ctr[rd_ptr_reg] : 4'h0;
  assign rsp_ill   = rsp_valid ? mem_ill[rd_ptr_reg] : 1'b0;
  assign busy      = (inflight != 16'd0) | rsp_valid;

`ifdef ALU_ISSUE_CHECK_EN
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] c);
    case (c)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      4'b1011: return ~a;
      4'b1100: return {1'b0, a[7:1]};
      4'b1101: return {a[6:0], 1'b0};
      4'b1110: return {a[0], a[7:1]};
      4'b1111: return {a[6:0], a[7]};
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0] exp_reg [ALU_LAT];
  logic       chk_err_reg, chk_flag;

  assign chk_flag = (push & ~dl_ill_reg[ALU_LAT-1] & (alu_o != exp_reg[ALU_LAT-1]))
                  | (push & ~pop & (count_reg == CW'(FIFO_DEPTH)))
                  | (pop & (count_reg == '0));

  always_ff @(posedge ck) begin
    if (rst) begin
      chk_err_reg <= 1'b0;
      for (int i = 0; i < ALU_LAT; i++) exp_reg[i] <= '0;
    end else begin
      chk_err_reg <= chk_flag;
      exp_reg[0]  <= alu_fn(req_a, req_b, req_ctr);
      for (int i = 1; i < ALU_LAT; i++) exp_reg[i] <= exp_reg[i-1];
    end
  end

  assign chk_err = chk_err_reg;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a 3-stage pipelined ALU model driving alu_o.
module tb_alu_issue_ctrl;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic       ck = 1'b0, rst = 1'b1, req_valid = 1'b0, rsp_ready = 1'b0;
  logic [7:0] req_a = '0, req_b = '0;
  logic [3:0] req_ctr = '0;
  logic       req_ready, rsp_valid, rsp_ill, busy;
  logic [7:0] alu_a, alu_b, alu_o, rsp_data;
  logic [3:0] alu_ctr, rsp_ctr;
`ifdef ALU_ISSUE_CHECK_EN
  logic       chk_err;
  int         err_cycles = 0;
`endif

  int          checks = 0, failures = 0;
  int          n_pop = 0;
  int unsigned cyc = 0;
  logic        rst_prev = 1'b1;
  logic [7:0]  p0 = '0, p1 = '0, inj_mask = '0;

  typedef struct {
    logic [7:0]  data;
    logic [3:0]  ctr;
    logic        ill;
    int unsigned acc_edge;
  } exp_t;
  exp_t        sb[$];
  exp_t        e;
  logic [7:0]  obs_data[$];
  logic        obs_ill[$];
  int unsigned obs_edge[$], obs_lat[$];

  alu_issue_ctrl #(.ALU_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .ck(ck), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctr(req_ctr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_o(alu_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_ctr(rsp_ctr), .rsp_ill(rsp_ill),
    .busy(busy)
`ifdef ALU_ISSUE_CHECK_EN
    , .chk_err(chk_err)
`endif
  );

  always #5 ck = ~ck;

  function automatic logic ref_legal(input logic [3:0] c);
    return (c == 4'h0) || (c == 4'h1) || (c >= 4'h9);
  endfunction

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] c);
    logic [15:0] aa;
    aa = {a, a};
    case (c)
      4'h0:    return 8'(a + b);
      4'h1:    return 8'(a - b);
      4'h9:    return a | b;
      4'hA:    return a ^ b;
      4'hB:    return 8'hFF ^ a;
      4'hC:    return a >> 1;
      4'hD:    return 8'(a << 1);
      4'hE:    return aa[8:1];
      4'hF:    return aa[14:7];
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ALU model: result appears on alu_o for the edge LAT cycles after the operand load
  always @(posedge ck) begin
    cyc      <= cyc + 1;
    rst_prev <= rst;
    p0       <= ref_alu(alu_a, alu_b, alu_ctr);
    p1       <= p0;
  end
  assign alu_o = p1 ^ inj_mask;

  // Monitor: handshakes seen here complete on the next rising edge
  always @(negedge ck) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (!rst_prev) begin
        chk("credit", 32'(req_ready), 32'(sb.size() < DEPTH));
        chk("busy", 32'(busy), 32'(sb.size() != 0));
      end
      chk("alu_ctr_legal", 32'(ref_legal(alu_ctr)), 32'd1);
      chk("rsp_unexpected", 32'(rsp_valid && sb.size() == 0), 32'd0);
`ifdef ALU_ISSUE_CHECK_EN
      if (chk_err) err_cycles++;
`endif
      if (rsp_valid && rsp_ready && sb.size() != 0) begin
        e = sb.pop_front();
        n_pop++;
        $display("rsp edge=%0d data=%02h ctr=%b ill=%0d", cyc + 1, rsp_data, rsp_ctr, rsp_ill);
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_ctr", 32'(rsp_ctr), 32'(e.ctr));
        chk("rsp_ill", 32'(rsp_ill), 32'(e.ill));
        obs_data.push_back(rsp_data);
        obs_ill.push_back(rsp_ill);
        obs_edge.push_back(cyc + 1);
        obs_lat.push_back(cyc + 1 - e.acc_edge);
      end
      if (req_valid && req_ready) begin
        e.ill      = !ref_legal(req_ctr);
        e.data     = e.ill ? 8'h00 : (ref_alu(req_a, req_b, req_ctr) ^ inj_mask);
        e.ctr      = req_ctr;
        e.acc_edge = cyc + 1;
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    logic done;
    done = 1'b0;
    req_a = a; req_b = b; req_ctr = c; req_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge ck);
      if (req_ready) done = 1'b1;
      @(posedge ck); #1;
    end
    chk("send_timeout", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge ck); #1;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic clear_obs();
    obs_data.delete(); obs_ill.delete(); obs_edge.delete(); obs_lat.delete();
  endtask

  task automatic set_op(input int idx);
    req_a   = 8'(idx * 16 + 3);
    req_b   = 8'h11;
    req_ctr = (idx % 2 == 1) ? 4'hA : 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t3_exp [4];
    int idx, pops_at5, pops_base;
    t3_exp = '{8'hFE, 8'hC0, 8'h03, 8'hF0};

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge ck);
    #1;
    chk("reset_alu", 32'({alu_a, alu_b, alu_ctr}), 32'd0);
    chk("reset_rsp", 32'({req_ready, rsp_valid, busy, rsp_data, rsp_ctr, rsp_ill}), 32'd0);
    rst = 1'b0;
    @(posedge ck); #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    chk("busy_after_rst", 32'(busy), 32'd0);

    // Single add
    rsp_ready = 1'b1;
    clear_obs();
    send(8'hF0, 8'h20, 4'h0);
    req_valid = 1'b0;
    drain();
    chk("t2_count", 32'(obs_data.size()), 32'd1);
    if (obs_data.size() >= 1) begin
      chk("t2_data", 32'(obs_data[0]), 32'h10);
      chk("t2_latency", obs_lat[0], 32'(LAT + 1));
    end

    // Burst of four, one response per cycle
    clear_obs();
    send(8'h05, 8'h07, 4'h1);
    send(8'h81, 8'h00, 4'hE);
    send(8'h81, 8'h00, 4'hF);
    send(8'h0F, 8'h00, 4'hB);
    req_valid = 1'b0;
    drain();
    chk("t3_count", 32'(obs_data.size()), 32'd4);
    if (obs_data.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("t3_data", 32'(obs_data[k]), 32'(t3_exp[k]));
      for (int k = 1; k < 4; k++) chk("t3_b2b", obs_edge[k] - obs_edge[k-1], 32'd1);
    end

    // Backpressure: six offered, only four credits
    clear_obs();
    rsp_ready = 1'b0;
    idx = 0;
    pops_base = n_pop;
    pops_at5 = 0;
    set_op(idx);
    req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge ck);
      if (req_ready) idx++;
      @(posedge ck); #1;
      set_op(idx);
    end
    chk("t4_accepted", 32'(idx), 32'd4);
    chk("t4_ready_low", 32'(req_ready), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && idx < 6; i++) begin
      @(negedge ck);
      if (req_ready) begin
        if (idx == 4) pops_at5 = n_pop - pops_base;
        idx++;
      end
      @(posedge ck); #1;
      if (idx < 6) set_op(idx);
      else req_valid = 1'b0;
    end
    req_valid = 1'b0;
    chk("t4_total", 32'(idx), 32'd6);
    chk("t4_pop_first", 32'(pops_at5 >= 1), 32'd1);
    drain();
    chk("t4_rsp_count", 32'(obs_data.size()), 32'd6);

    // Illegal opcode between two adds
    clear_obs();
    send(8'h10, 8'h20, 4'h0);
    send(8'h33, 8'h44, 4'h5);
    chk("t5_hold_a", 32'(alu_a), 32'h10);
    chk("t5_hold_ctr", 32'(alu_ctr), 32'h0);
    send(8'h01, 8'h02, 4'h0);
    req_valid = 1'b0;
    drain();
    chk("t5_count", 32'(obs_data.size()), 32'd3);
    if (obs_data.size() == 3) begin
      chk("t5_ill", 32'({obs_ill[0], obs_ill[1], obs_ill[2]}), 32'b010);
      chk("t5_data_mid", 32'(obs_data[1]), 32'h00);
      chk("t5_data_last", 32'(obs_data[2]), 32'h03);
    end

    // Reset with two ops in flight
    send(8'h01, 8'h01, 4'h0);
    send(8'h02, 8'h02, 4'h1);
    req_valid = 1'b0;
    rst = 1'b1;
    pops_base = n_pop;
    repeat (2) @(posedge ck);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge ck);
    #1;
    chk("t6_no_rsp", 32'(n_pop), 32'(pops_base));
    chk("t6_idle", 32'({busy, rsp_valid}), 32'd0);

`ifdef ALU_ISSUE_CHECK_EN
    chk("chk_err_quiet", 32'(err_cycles), 32'd0);
    err_cycles = 0;
    inj_mask = 8'h04;
    send(8'h05, 8'h03, 4'h0);
    req_valid = 1'b0;
    drain();
    inj_mask = 8'h00;
    repeat (3) @(posedge ck);
    #1;
    chk("chk_err_pulse", 32'(err_cycles), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
